instr_queue_register: RTL and testbench
=======================================

Name: instr_queue_register

Overview:
- Parametrised successor to the single-entry instruction register of the multi-cycle datapath.
- A DEPTH-entry prefetch queue sits between instruction memory and the instruction register (IR), so fetch can run ahead of decode.
- The IR stage pops the queue head and registers the decoded fields (opcode, funct, register addresses, offset) for the control unit and register file.
- A flush input empties the queue and invalidates the IR on branch or jump redirect.

Parameters:
- INSTR_W, 16: instruction width in bits; must satisfy INSTR_W >= OPC_W + 3*REG_W.
- OPC_W, 4: opcode field width, taken from bits [INSTR_W-1 -: OPC_W].
- REG_W, 4: register-address / funct field width; must be even.
- DEPTH, 4: number of queue entries, >= 2; need not be a power of 2.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- D_MemData  in  INSTR_W  fetched instruction word.
- C_FetchValid  in  1  D_MemData is valid this cycle.
- C_FetchReady  out  1  queue can accept a word; equals (count < DEPTH) && rst.
- C_IRWrite  in  1  pop the queue head into the IR.
- C_Flush  in  1  synchronous flush.
- D_Instr  out  INSTR_W  registered full instruction.
- OPCODE  out  OPC_W  D_Instr[INSTR_W-1 -: OPC_W].
- FUNCFIELD  out  REG_W  D_Instr[REG_W-1:0].
- A_ReadReg1RT  out  REG_W  D_Instr[2*REG_W-1:REG_W].
- A_ReadReg2RT  out  REG_W  D_Instr[REG_W-1:0].
- A_WriteRegRT_BT  out  REG_W  D_Instr[3*REG_W-1:2*REG_W].
- A_Offset  out  REG_W/2  D_Instr[2*REG_W +: REG_W/2].
- A_RegSWLW  out  REG_W/2  D_Instr[3*REG_W-1 -: REG_W/2].
- C_IRValid  out  1  IR holds a valid instruction.
- C_Count  out  $clog2(DEPTH+1)  current queue occupancy.

Behaviour:
- Reset (rst=0, asynchronous):
  - IR: D_Instr, all field outputs and C_IRValid clear to 0.
  - Queue: read pointer, write pointer and count clear to 0.
  - Queue storage contents are don't-care.
- Push: C_FetchValid && C_FetchReady writes D_MemData at the write pointer; pointer wraps DEPTH-1 -> 0; count +1.
- Push while full (C_FetchValid=1, C_FetchReady=0): word is dropped, no state change. The fetch unit must hold the word and retry.
- Pop: C_IRWrite && count>0 at edge n:
  - Head word is loaded into D_Instr and all fields, visible after edge n.
  - C_IRValid <= 1; read pointer wraps; count -1.
- Pop when empty (C_IRWrite=1, count=0): C_IRValid <= 0; D_Instr and fields hold their previous values.
- No pop: C_IRValid, D_Instr and fields hold.
- Latency: no bypass.
  - A word pushed at edge n is poppable at edge n+1.
  - Its fields appear after edge n+1.
  - A pop from empty never captures same-cycle D_MemData.
- Simultaneous push and pop with 0 < count < DEPTH: both happen, count unchanged.
- Simultaneous push and pop when full: pop happens, push dropped (ready is based on registered count). Count = DEPTH-1 afterwards.
- Flush has priority over push and pop in the same cycle:
  - Pointers and count go to 0; C_IRValid <= 0.
  - D_Instr and fields hold.
  - Any same-cycle push is dropped.
- Field outputs are registered copies and always equal the slices of D_Instr listed in Ports.
- C_Count is always in 0..DEPTH.

Optional Feature:
- Macro IR_PARITY_EN.
- Defined:
  - Adds input D_MemParity (1 bit, even parity over D_MemData), stored alongside each queue entry.
  - Adds output C_ParityErr, reset 0.
  - On pop, if the stored parity does not match the recomputed parity, C_ParityErr <= 1. It is sticky until C_Flush or reset.
  - The instruction is still loaded into the IR.
- Undefined: neither port exists, no parity storage, behaviour otherwise identical.

Test Plan:
- Reset mid-stream: 3 words queued, pull rst low asynchronously between edges -> C_Count=0, C_IRValid=0, D_Instr=16'h0000 immediately; C_FetchReady=0 while rst=0 and 1 after release.
- Field decode: push 16'hA5C3, pop -> OPCODE=4'hA, A_WriteRegRT_BT=4'h5, A_RegSWLW=2'b01, A_Offset=2'b01, A_ReadReg1RT=4'hC, A_ReadReg2RT=FUNCFIELD=4'h3, C_IRValid=1.
- Fill and wrap (DEPTH=4): push 16'h1001..16'h1006 continuously -> first 4 accepted, C_FetchReady=0 at C_Count=4. Then pop 4, push 2 more, pop 2 -> IR sequence 1001,1002,1003,1004 then the next two accepted words, in order across pointer wrap.
- Full with simultaneous push and pop: count=4, push 16'hBEEF and pop in same cycle -> BEEF dropped, C_Count=3, IR gets the oldest entry.
- Flush priority: count=2, assert C_Flush with C_FetchValid and C_IRWrite -> C_Count=0, C_IRValid=0, D_Instr unchanged. A following pop from empty keeps C_IRValid=0.
- IR_PARITY_EN: push 16'h0001 with D_MemParity=0 and pop -> C_ParityErr=1; it stays 1 across later good pops and clears on C_Flush.

Source files
------------

// File: rtl/instr_queue_register.sv
// DEPTH-entry instruction prefetch queue feeding a registered IR with decoded field outputs.
// Optional stored-parity checking on pop is enabled by defining IR_PARITY_EN.
module instr_queue_register #(
    parameter int INSTR_W = 16,
    parameter int OPC_W   = 4,
    parameter int REG_W   = 4,
    parameter int DEPTH   = 4,
    localparam int CNT_W  = $clog2(DEPTH + 1),
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] D_MemData,
    input  logic               C_FetchValid,
    output logic               C_FetchReady,
    input  logic               C_IRWrite,
    input  logic               C_Flush,
`ifdef IR_PARITY_EN
    input  logic               D_MemParity,
    output logic               C_ParityErr,
`endif
    output logic [INSTR_W-1:0] D_Instr,
    output logic [OPC_W-1:0]   OPCODE,
    output logic [REG_W-1:0]   FUNCFIELD,
    output logic [REG_W-1:0]   A_ReadReg1RT,
    output logic [REG_W-1:0]   A_ReadReg2RT,
    output logic [REG_W-1:0]   A_WriteRegRT_BT,
    output logic [REG_W/2-1:0] A_Offset,
    output logic [REG_W/2-1:0] A_RegSWLW,
    output logic               C_IRValid,
    output logic [CNT_W-1:0]   C_Count
);

    logic [INSTR_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               ir_valid_q, ir_valid_d;
    logic               do_push, do_pop;
`ifdef IR_PARITY_EN
    logic               par_mem_q [DEPTH];
    logic               par_err_q, par_err_d;
`endif

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Ready is derived from the registered count only, so a pop never frees room for a same-cycle push.
    assign C_FetchReady = (count_q < CNT_W'(DEPTH)) && rst;
    assign do_push      = C_FetchValid && C_FetchReady && !C_Flush;
    assign do_pop       = C_IRWrite && (count_q != '0) && !C_Flush;

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        instr_d    = instr_q;
        ir_valid_d = ir_valid_q;
`ifdef IR_PARITY_EN
        par_err_d  = par_err_q;
`endif
        if (C_Flush) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            ir_valid_d = 1'b0;
`ifdef IR_PARITY_EN
            par_err_d  = 1'b0;
`endif
        end else begin
            if (do_push) begin
                wr_ptr_d = wrap_inc(wr_ptr_q);
            end
            if (C_IRWrite) begin
                if (do_pop) begin
                    instr_d    = mem_q[rd_ptr_q];
                    ir_valid_d = 1'b1;
                    rd_ptr_d   = wrap_inc(rd_ptr_q);
`ifdef IR_PARITY_EN
                    if (par_mem_q[rd_ptr_q] != ^mem_q[rd_ptr_q]) begin
                        par_err_d = 1'b1;
                    end
`endif
                end else begin
                    ir_valid_d = 1'b0;
                end
            end
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            instr_q    <= '0;
            ir_valid_q <= 1'b0;
`ifdef IR_PARITY_EN
            par_err_q  <= 1'b0;
`endif
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            instr_q    <= instr_d;
            ir_valid_q <= ir_valid_d;
`ifdef IR_PARITY_EN
            par_err_q  <= par_err_d;
`endif
        end
    end

    // Storage is not reset; only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= D_MemData;
`ifdef IR_PARITY_EN
            par_mem_q[wr_ptr_q] <= D_MemParity;
`endif
        end
    end

    assign D_Instr         = instr_q;
    assign OPCODE          = instr_q[INSTR_W-1 -: OPC_W];
    assign FUNCFIELD       = instr_q[REG_W-1:0];
    assign A_ReadReg1RT    = instr_q[2*REG_W-1:REG_W];
    assign A_ReadReg2RT    = instr_q[REG_W-1:0];
    assign A_WriteRegRT_BT = instr_q[3*REG_W-1:2*REG_W];
    assign A_Offset        = instr_q[2*REG_W +: REG_W/2];
    assign A_RegSWLW       = instr_q[3*REG_W-1 -: REG_W/2];
    assign C_IRValid       = ir_valid_q;
    assign C_Count         = count_q;
`ifdef IR_PARITY_EN
    assign C_ParityErr     = par_err_q;
`endif

endmodule

// File: tb/tb_instr_queue_register.sv
// Directed self-checking bench for instr_queue_register (DEPTH=4, 16-bit instructions).
// Parity checks are compiled in when IR_PARITY_EN is defined.
module tb_instr_queue_register;

    logic        clk;
    logic        rst;
    logic [15:0] D_MemData;
    logic        C_FetchValid;
    logic        C_FetchReady;
    logic        C_IRWrite;
    logic        C_Flush;
    logic [15:0] D_Instr;
    logic [3:0]  OPCODE;
    logic [3:0]  FUNCFIELD;
    logic [3:0]  A_ReadReg1RT;
    logic [3:0]  A_ReadReg2RT;
    logic [3:0]  A_WriteRegRT_BT;
    logic [1:0]  A_Offset;
    logic [1:0]  A_RegSWLW;
    logic        C_IRValid;
    logic [2:0]  C_Count;
`ifdef IR_PARITY_EN
    logic        D_MemParity;
    logic        C_ParityErr;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    instr_queue_register #(
        .INSTR_W(16),
        .OPC_W  (4),
        .REG_W  (4),
        .DEPTH  (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .D_MemData      (D_MemData),
        .C_FetchValid   (C_FetchValid),
        .C_FetchReady   (C_FetchReady),
        .C_IRWrite      (C_IRWrite),
        .C_Flush        (C_Flush),
`ifdef IR_PARITY_EN
        .D_MemParity    (D_MemParity),
        .C_ParityErr    (C_ParityErr),
`endif
        .D_Instr        (D_Instr),
        .OPCODE         (OPCODE),
        .FUNCFIELD      (FUNCFIELD),
        .A_ReadReg1RT   (A_ReadReg1RT),
        .A_ReadReg2RT   (A_ReadReg2RT),
        .A_WriteRegRT_BT(A_WriteRegRT_BT),
        .A_Offset       (A_Offset),
        .A_RegSWLW      (A_RegSWLW),
        .C_IRValid      (C_IRValid),
        .C_Count        (C_Count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        C_FetchValid = 1'b0;
        C_IRWrite    = 1'b0;
        C_Flush      = 1'b0;
    endtask

    task automatic push_word(input logic [15:0] w);
        D_MemData    = w;
`ifdef IR_PARITY_EN
        D_MemParity  = ^w;
`endif
        C_FetchValid = 1'b1;
        C_IRWrite    = 1'b0;
        tick();
        idle();
    endtask

    task automatic test_reset();
        n_checks += 5;
        if (C_Count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", C_Count); end
        if (C_IRValid !== 1'b0) begin n_fail++; $display("FAIL reset_irvalid got %b want 0", C_IRValid); end
        if (D_Instr !== 16'h0000) begin n_fail++; $display("FAIL reset_instr got %h want 0000", D_Instr); end
        if (C_FetchReady !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", C_FetchReady); end
        if ({OPCODE, A_WriteRegRT_BT, A_ReadReg1RT, FUNCFIELD} !== 16'h0000) begin
            n_fail++; $display("FAIL reset_fields got %h want 0000", {OPCODE, A_WriteRegRT_BT, A_ReadReg1RT, FUNCFIELD});
        end
    endtask

    task automatic test_field_decode();
        push_word(16'hA5C3);
        C_IRWrite = 1'b1;
        tick();
        idle();
        n_checks += 9;
        if (OPCODE !== 4'hA) begin n_fail++; $display("FAIL dec_opcode got %h want a", OPCODE); end
        if (A_WriteRegRT_BT !== 4'h5) begin n_fail++; $display("FAIL dec_wr got %h want 5", A_WriteRegRT_BT); end
        if (A_RegSWLW !== 2'b01) begin n_fail++; $display("FAIL dec_swlw got %b want 01", A_RegSWLW); end
        if (A_Offset !== 2'b01) begin n_fail++; $display("FAIL dec_offset got %b want 01", A_Offset); end
        if (A_ReadReg1RT !== 4'hC) begin n_fail++; $display("FAIL dec_rr1 got %h want c", A_ReadReg1RT); end
        if (A_ReadReg2RT !== 4'h3) begin n_fail++; $display("FAIL dec_rr2 got %h want 3", A_ReadReg2RT); end
        if (FUNCFIELD !== 4'h3) begin n_fail++; $display("FAIL dec_func got %h want 3", FUNCFIELD); end
        if (C_IRValid !== 1'b1) begin n_fail++; $display("FAIL dec_irvalid got %b want 1", C_IRValid); end
        if (C_Count !== 3'd0) begin n_fail++; $display("FAIL dec_count got %0d want 0", C_Count); end
    endtask

    task automatic test_fill_wrap();
        logic [15:0] exp_ir [6];
        exp_ir = '{16'h1001, 16'h1002, 16'h1003, 16'h1004, 16'h1005, 16'h1006};
        for (int i = 0; i < 6; i++) begin
            D_MemData    = 16'h1001 + 16'(i);
`ifdef IR_PARITY_EN
            D_MemParity  = ^D_MemData;
`endif
            C_FetchValid = 1'b1;
            n_checks++;
            if (C_FetchReady !== (i < 4)) begin
                n_fail++; $display("FAIL fill_ready[%0d] got %b want %b", i, C_FetchReady, (i < 4));
            end
            tick();
        end
        idle();
        n_checks++;
        if (C_Count !== 3'd4) begin n_fail++; $display("FAIL fill_count got %0d want 4", C_Count); end
        for (int i = 0; i < 4; i++) begin
            C_IRWrite = 1'b1;
            tick();
            n_checks++;
            if (D_Instr !== exp_ir[i]) begin n_fail++; $display("FAIL wrap_pop[%0d] got %h want %h", i, D_Instr, exp_ir[i]); end
        end
        idle();
        push_word(16'h1005);
        push_word(16'h1006);
        for (int i = 4; i < 6; i++) begin
            C_IRWrite = 1'b1;
            tick();
            n_checks++;
            if (D_Instr !== exp_ir[i]) begin n_fail++; $display("FAIL wrap_pop[%0d] got %h want %h", i, D_Instr, exp_ir[i]); end
        end
        idle();
        n_checks++;
        if (C_Count !== 3'd0) begin n_fail++; $display("FAIL wrap_count got %0d want 0", C_Count); end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 4; i++) push_word(16'h2001 + 16'(i));
        D_MemData    = 16'hBEEF;
`ifdef IR_PARITY_EN
        D_MemParity  = ^D_MemData;
`endif
        C_FetchValid = 1'b1;
        C_IRWrite    = 1'b1;
        tick();
        idle();
        n_checks += 2;
        if (C_Count !== 3'd3) begin n_fail++; $display("FAIL full_pp_count got %0d want 3", C_Count); end
        if (D_Instr !== 16'h2001) begin n_fail++; $display("FAIL full_pp_instr got %h want 2001", D_Instr); end
        for (int i = 1; i < 4; i++) begin
            C_IRWrite = 1'b1;
            tick();
            n_checks++;
            if (D_Instr !== 16'h2001 + 16'(i)) begin
                n_fail++; $display("FAIL full_drain[%0d] got %h want %h", i, D_Instr, 16'h2001 + 16'(i));
            end
        end
        tick();
        idle();
        n_checks += 3;
        if (C_IRValid !== 1'b0) begin n_fail++; $display("FAIL empty_pop_irvalid got %b want 0", C_IRValid); end
        if (D_Instr !== 16'h2004) begin n_fail++; $display("FAIL empty_pop_instr got %h want 2004", D_Instr); end
        if (C_Count !== 3'd0) begin n_fail++; $display("FAIL empty_pop_count got %0d want 0", C_Count); end
    endtask

    task automatic test_flush();
        push_word(16'h3001);
        push_word(16'h3002);
        push_word(16'h3003);
        C_IRWrite = 1'b1;
        tick();
        idle();
        n_checks += 2;
        if (C_Count !== 3'd2) begin n_fail++; $display("FAIL flush_pre_count got %0d want 2", C_Count); end
        if (C_IRValid !== 1'b1) begin n_fail++; $display("FAIL flush_pre_irvalid got %b want 1", C_IRValid); end
        D_MemData    = 16'h3004;
        C_FetchValid = 1'b1;
        C_IRWrite    = 1'b1;
        C_Flush      = 1'b1;
        tick();
        idle();
        n_checks += 3;
        if (C_Count !== 3'd0) begin n_fail++; $display("FAIL flush_count got %0d want 0", C_Count); end
        if (C_IRValid !== 1'b0) begin n_fail++; $display("FAIL flush_irvalid got %b want 0", C_IRValid); end
        if (D_Instr !== 16'h3001) begin n_fail++; $display("FAIL flush_instr got %h want 3001", D_Instr); end
        C_IRWrite = 1'b1;
        tick();
        idle();
        n_checks += 3;
        if (C_IRValid !== 1'b0) begin n_fail++; $display("FAIL flush_empty_irvalid got %b want 0", C_IRValid); end
        if (C_Count !== 3'd0) begin n_fail++; $display("FAIL flush_empty_count got %0d want 0", C_Count); end
        if (D_Instr !== 16'h3001) begin n_fail++; $display("FAIL flush_empty_instr got %h want 3001", D_Instr); end
    endtask

`ifdef IR_PARITY_EN
    task automatic test_parity();
        n_checks++;
        if (C_ParityErr !== 1'b0) begin n_fail++; $display("FAIL par_init got %b want 0", C_ParityErr); end
        D_MemData = 16'h0001; D_MemParity = 1'b0; C_FetchValid = 1'b1;
        tick();
        D_MemData = 16'h0003; D_MemParity = 1'b0;
        tick();
        idle();
        C_IRWrite = 1'b1;
        tick();
        n_checks += 2;
        if (C_ParityErr !== 1'b1) begin n_fail++; $display("FAIL par_err got %b want 1", C_ParityErr); end
        if (D_Instr !== 16'h0001) begin n_fail++; $display("FAIL par_instr got %h want 0001", D_Instr); end
        tick();
        idle();
        n_checks += 2;
        if (C_ParityErr !== 1'b1) begin n_fail++; $display("FAIL par_sticky got %b want 1", C_ParityErr); end
        if (D_Instr !== 16'h0003) begin n_fail++; $display("FAIL par_good_instr got %h want 0003", D_Instr); end
        C_Flush = 1'b1;
        tick();
        idle();
        n_checks++;
        if (C_ParityErr !== 1'b0) begin n_fail++; $display("FAIL par_flush got %b want 0", C_ParityErr); end
    endtask
`endif

    task automatic test_reset_midstream();
        for (int i = 0; i < 4; i++) push_word(16'h4001 + 16'(i));
        C_IRWrite = 1'b1;
        tick();
        idle();
        n_checks += 2;
        if (C_Count !== 3'd3) begin n_fail++; $display("FAIL mid_pre_count got %0d want 3", C_Count); end
        if (D_Instr !== 16'h4001) begin n_fail++; $display("FAIL mid_pre_instr got %h want 4001", D_Instr); end
        #2;
        rst = 1'b0;
        #1;
        n_checks += 4;
        if (C_Count !== 3'd0) begin n_fail++; $display("FAIL mid_count got %0d want 0", C_Count); end
        if (C_IRValid !== 1'b0) begin n_fail++; $display("FAIL mid_irvalid got %b want 0", C_IRValid); end
        if (D_Instr !== 16'h0000) begin n_fail++; $display("FAIL mid_instr got %h want 0000", D_Instr); end
        if (C_FetchReady !== 1'b0) begin n_fail++; $display("FAIL mid_ready_low got %b want 0", C_FetchReady); end
        tick();
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (C_FetchReady !== 1'b1) begin n_fail++; $display("FAIL mid_ready_rel got %b want 1", C_FetchReady); end
    endtask

    initial begin
        rst       = 1'b0;
        D_MemData = '0;
`ifdef IR_PARITY_EN
        D_MemParity = 1'b0;
`endif
        idle();
        #12;
        rst = 1'b1;
        tick();
        test_reset();
        test_field_decode();
        test_fill_wrap();
        test_full_push_pop();
        test_flush();
`ifdef IR_PARITY_EN
        test_parity();
`endif
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout reached without completion");
        $fatal(1);
    end

endmodule
